// File: rtl/inst_mem_if.sv
// Loader and fetch bundle for inst_mem_loadable. The loader/fetch side is the
// master; the memory is the slave.
interface inst_mem_if #(
    parameter int INST_W = 9,
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic              prog_valid;
    logic              prog_ready;
    logic [INST_W-1:0] prog_data;
    logic              prog_last;
    logic              fetch_req;
    logic [ADDR_W-1:0] inst_address;
    logic [INST_W-1:0] inst_out;
    logic              inst_valid;
    logic [ADDR_W:0]   prog_len;
    logic              loaded;
    logic              fault;

    modport master (
        output load_start, prog_valid, prog_data, prog_last, fetch_req, inst_address,
        input  prog_ready, inst_out, inst_valid, prog_len, loaded, fault
    );

    modport slave (
        input  load_start, prog_valid, prog_data, prog_last, fetch_req, inst_address,
        output prog_ready, inst_out, inst_valid, prog_len, loaded, fault
    );
endinterface

// File: rtl/inst_mem_loadable.sv
// Runtime-loadable instruction RAM: filled over a ready/valid stream, read with
// one cycle of latency. Fetches outside the loaded program return HALT_WORD.
module inst_mem_loadable #(
    parameter int                INST_W    = 9,
    parameter int                ADDR_W    = 10,
    parameter logic [INST_W-1:0] HALT_WORD = '1
) (
    input  logic       clk,
    input  logic       rst_n,
    inst_mem_if.slave  bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q;
    logic [ADDR_W:0]   len_q;
    logic              fault_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;
    logic [INST_W-1:0] mem [DEPTH];

    logic ready;
    logic beat;
    logic in_range;
    logic fetch_ok;

    // A LoadStart in RUN retires the old program in that same cycle.
    assign ready    = (state_q == LOAD) && !bus.load_start;
    assign beat     = bus.prog_valid && ready;
    assign in_range = {1'b0, bus.inst_address} < len_q;
    assign fetch_ok = (state_q == RUN) && !bus.load_start;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.load_start) state_d = LOAD;
            LOAD: begin
                if (bus.load_start)
                    state_d = LOAD;
                else if (beat && (bus.prog_last || wptr_q == LAST_ADDR))
                    state_d = RUN;
            end
            RUN:  if (bus.load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            len_q   <= '0;
            fault_q <= 1'b0;
            inst_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (bus.load_start) begin
                wptr_q <= '0;
                len_q  <= '0;
            end else if (beat) begin
                wptr_q <= wptr_q + 1'b1;
                len_q  <= {1'b0, wptr_q} + 1'b1;
            end

            if (bus.load_start)
                fault_q <= 1'b0;
            else if (bus.fetch_req && fetch_ok && !in_range)
                fault_q <= 1'b1;

            valid_q <= bus.fetch_req;
            if (bus.fetch_req)
                inst_q <= (fetch_ok && in_range) ? mem[bus.inst_address] : HALT_WORD;
        end
    end

    // NOTE: the storage array is deliberately not reset; ProgLen gates what is reachable.
    always_ff @(posedge clk) begin
        if (beat)
            mem[wptr_q] <= bus.prog_data;
    end

    assign bus.prog_ready = ready;
    assign bus.inst_out   = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.prog_len   = len_q;
    assign bus.loaded     = (state_q == RUN);
    assign bus.fault      = fault_q;
endmodule
